// File: rtl/pc_sequencer_if.sv
// Bus between the EX-stage control-flow decode / next-address mux and the PC sequencer.
// The master side drives the flags and the mux output; the slave side is the sequencer.
interface pc_sequencer_if #(
  parameter int PTR_W = 3
);
  logic             stall;
  logic             is_branch;
  logic             branch_taken;
  logic             is_jump;
  logic             is_call;
  logic             is_jr;
  logic             is_ret;
  logic             is_halt;
  logic             resume;
  logic [31:0]      next_address;
  logic [31:0]      pc;
  logic [31:0]      pc_1;
  logic [31:0]      stack_top;
  logic [2:0]       pc_select;
  logic             halted;
  logic [PTR_W:0]   stack_depth;
  logic             fault;

  modport master (
    output stall, is_branch, branch_taken, is_jump, is_call, is_jr, is_ret, is_halt,
           resume, next_address,
    input  pc, pc_1, stack_top, pc_select, halted, stack_depth, fault
  );

  modport slave (
    input  stall, is_branch, branch_taken, is_jump, is_call, is_jr, is_ret, is_halt,
           resume, next_address,
    output pc, pc_1, stack_top, pc_select, halted, stack_depth, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC register, next-address mux select and hardware return-address stack for EX.
// RUN/HALTED/FAULT control; stack over/underflow parks the core in a sticky FAULT.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STACK_DEPTH = 8,
  parameter int          PTR_W       = 3
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [2:0] SEL_STACK  = 3'b000;
  localparam logic [2:0] SEL_JR     = 3'b001;
  localparam logic [2:0] SEL_NPC    = 3'b010;
  localparam logic [2:0] SEL_JUMP   = 3'b011;
  localparam logic [2:0] SEL_BRANCH = 3'b100;
  localparam logic [2:0] SEL_HALT   = 3'b101;

  localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W + 1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] DEPTH_ONE  = {{PTR_W{1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [31:0]      pc_r;
  logic [31:0]      pc_1_r;
  logic [PTR_W:0]   depth_r;
  logic             fault_r;
  logic             halted_r;
  logic [31:0]      entries_r [STACK_DEPTH];

  logic [2:0]       sel_s;
  logic [1:0]       next_state_s;
  logic             push_s;
  logic             pop_s;
  logic             fault_set_s;
  logic [PTR_W:0]   depth_m1_s;
  logic             depth_empty_s;
  logic             depth_full_s;

  assign depth_m1_s    = depth_r - DEPTH_ONE;
  assign depth_empty_s = (depth_r == {(PTR_W + 1){1'b0}});
  assign depth_full_s  = (depth_r == DEPTH_FULL);

  // Select the mux source and the stack/state action for this cycle.
  always_comb begin
    sel_s        = SEL_HALT;
    next_state_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    fault_set_s  = 1'b0;
    if (reset) begin
      sel_s = SEL_HALT;
    end else if (bus.stall) begin
      sel_s = SEL_HALT;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.is_halt) begin
            sel_s        = SEL_HALT;
            next_state_s = ST_HALTED;
          end else if (bus.is_ret) begin
            if (depth_empty_s) begin
              sel_s        = SEL_HALT;
              fault_set_s  = 1'b1;
              next_state_s = ST_FAULT;
            end else begin
              sel_s = SEL_STACK;
              pop_s = 1'b1;
            end
          end else if (bus.is_jr) begin
            sel_s = SEL_JR;
          end else if (bus.is_call) begin
            if (depth_full_s) begin
              sel_s        = SEL_HALT;
              fault_set_s  = 1'b1;
              next_state_s = ST_FAULT;
            end else begin
              sel_s  = SEL_JUMP;
              push_s = 1'b1;
            end
          end else if (bus.is_jump) begin
            sel_s = SEL_JUMP;
          end else if (bus.is_branch && bus.branch_taken) begin
            sel_s = SEL_BRANCH;
          end else begin
            sel_s = SEL_NPC;
          end
        end
        ST_HALTED: begin
          if (bus.resume) begin
            sel_s        = SEL_NPC;
            next_state_s = ST_RUN;
          end else begin
            sel_s = SEL_HALT;
          end
        end
        ST_FAULT: begin
          sel_s = SEL_HALT;
        end
        default: begin
          // An illegal encoding is treated like a stack fault so the core stays parked.
          sel_s        = SEL_HALT;
          fault_set_s  = 1'b1;
          next_state_s = ST_FAULT;
        end
      endcase
    end
  end

  // State, PC, depth and sticky flags; stall freezes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      pc_1_r   <= RESET_PC + 32'd1;
      depth_r  <= {(PTR_W + 1){1'b0}};
      fault_r  <= 1'b0;
      halted_r <= 1'b0;
    end else if (!bus.stall) begin
      state_r  <= next_state_s;
      pc_r     <= bus.next_address;
      pc_1_r   <= bus.next_address + 32'd1;
      fault_r  <= fault_r | fault_set_s;
      halted_r <= (next_state_s != ST_RUN);
      if (push_s) begin
        depth_r <= depth_r + DEPTH_ONE;
      end else if (pop_s) begin
        depth_r <= depth_m1_s;
      end
    end
  end

  // Return-address storage; a push writes the slot just above the current top.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        entries_r[i] <= 32'h0000_0000;
      end
    end else if (!bus.stall && push_s) begin
      entries_r[depth_r[PTR_W-1:0]] <= pc_1_r;
    end
  end

  assign bus.pc          = pc_r;
  assign bus.pc_1        = pc_1_r;
  assign bus.stack_top   = depth_empty_s ? 32'h0000_0000 : entries_r[depth_m1_s[PTR_W-1:0]];
  assign bus.pc_select   = sel_s;
  assign bus.halted      = halted_r;
  assign bus.stack_depth = depth_r;
  assign bus.fault       = fault_r;

endmodule
